// File: rtl/shifter8.sv
// shifter8: 8-bit registered shift unit.
// The single state register either holds its value, loads d_in, or shifts
// its own contents by 0-3 bits: logical left, logical right or arithmetic
// right. d_out is the register itself, so results appear one edge later.
module shifter8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic [1:0] shamt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out
);

  // Operation codes; 3'b101..3'b111 are reserved and fall through to hold.
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100
  } op_e;

  logic [7:0] q_reg;
  logic [7:0] q_next;

  // Op decode, kept apart from the datapath mux so each select is one gate.
  logic is_load;
  logic is_lsl;
  logic is_lsr;
  logic is_asr;

  assign is_load = (op == OP_LOAD);
  assign is_lsl  = (op == OP_LSL);
  assign is_lsr  = (op == OP_LSR);
  assign is_asr  = (op == OP_ASR);

  // Every shift type is precomputed for each constant amount; shamt then
  // just picks one entry. Shifting by 0 yields q_reg, so shamt=0 holds.
  logic [7:0] lsl_by [4];
  logic [7:0] lsr_by [4];
  logic [7:0] asr_by [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      assign lsl_by[gi] = q_reg << gi;
      assign lsr_by[gi] = q_reg >> gi;
      assign asr_by[gi] = 8'($signed(q_reg) >>> gi);
    end
  endgenerate

  // Next-state select: load, one of the shift results, or hold.
  always_comb begin
    q_next = q_reg;
    if (is_load) begin
      q_next = d_in;
    end else if (is_lsl) begin
      q_next = lsl_by[shamt];
    end else if (is_lsr) begin
      q_next = lsr_by[shamt];
    end else if (is_asr) begin
      q_next = asr_by[shamt];
    end
  end

  // State register; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= 8'h00;
    end else begin
      q_reg <= q_next;
    end
  end

  assign d_out = q_reg;

endmodule

// File: tb/tb_shifter8.sv
// tb_shifter8: scoreboard bench for shifter8.
// The driver issues one operation per cycle on the falling edge and queues
// the value d_out must hold after the next rising edge; the monitor pops
// and compares shortly after every rising edge.
module tb_shifter8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] op = 3'b000;
  logic [1:0] shamt = 2'b00;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  string      name_q [$];
  int         model_q = 0;

  shifter8 dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .shamt (shamt),
    .d_in  (d_in),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  // Reference behaviour expressed as arithmetic on integers.
  function automatic int ref_next(input int q, input int o, input int n, input int d);
    int p;
    int sv;
    p = 1 << n;
    case (o)
      1: return d;
      2: return (q * p) % 256;
      3: return q / p;
      4: begin
        sv = (q >= 128) ? q - 256 : q;
        if (sv < 0) sv = -((-sv + p - 1) / p);
        else        sv = sv / p;
        return sv & 255;
      end
      default: return q;
    endcase
  endfunction

  task automatic direct_check(input string nm, input logic [7:0] e);
    checks++;
    if (d_out !== e) begin
      errors++;
      $display("FAIL %s: d_out=%02h expected=%02h", nm, d_out, e);
    end else begin
      $display("check %s: d_out=%02h ok", nm, d_out);
    end
  endtask

  // One transaction: drive on the falling edge, queue the expected result.
  task automatic step(input logic rst_v, input logic [2:0] o, input logic [1:0] n,
                      input logic [7:0] d, input logic use_spec,
                      input logic [7:0] spec, input string nm);
    int nxt;
    @(negedge clk);
    reset = rst_v;
    op    = o;
    shamt = n;
    d_in  = d;
    nxt = rst_v ? 0 : ref_next(model_q, int'(o), int'(n), int'(d));
    model_q = nxt;
    exp_q.push_back(use_spec ? spec : 8'(nxt));
    name_q.push_back(nm);
  endtask

  // Monitor: compare once per rising edge whenever an expectation is pending.
  initial begin
    logic [7:0] e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (d_out !== e) begin
          errors++;
          $display("FAIL %s: op=%0d shamt=%0d d_in=%02h d_out=%02h expected=%02h",
                   nm, op, shamt, d_in, d_out, e);
        end else begin
          $display("txn %s: op=%0d shamt=%0d d_in=%02h d_out=%02h", nm, op, shamt, d_in, d_out);
        end
      end
    end
  end

  initial begin
    logic rst_v;
    int   waited;

    // Reset asserted at t0 clears the register before any clock edge.
    reset = 1'b1;
    op    = 3'b000;
    d_in  = 8'hB5;
    #2;
    direct_check("reset_t0", 8'h00);

    step(1'b0, 3'b000, 2'd0, 8'hB5, 1'b1, 8'h00, "nop_after_reset");
    step(1'b0, 3'b001, 2'd0, 8'hB5, 1'b1, 8'hB5, "load_b5");
    for (int i = 0; i < 3; i++)
      step(1'b0, 3'b000, 2'd0, 8'h00, 1'b1, 8'hB5, "nop_hold");

    step(1'b0, 3'b010, 2'd1, 8'h00, 1'b1, 8'h6A, "lsl1");
    step(1'b0, 3'b011, 2'd1, 8'h00, 1'b1, 8'h35, "lsr1");
    step(1'b0, 3'b100, 2'd1, 8'h00, 1'b1, 8'h1A, "asr1");

    step(1'b0, 3'b001, 2'd0, 8'hB5, 1'b1, 8'hB5, "load_b5");
    step(1'b0, 3'b100, 2'd2, 8'h00, 1'b1, 8'hED, "asr2");
    step(1'b0, 3'b001, 2'd0, 8'hB5, 1'b1, 8'hB5, "load_b5");
    step(1'b0, 3'b011, 2'd3, 8'h00, 1'b1, 8'h16, "lsr3");
    step(1'b0, 3'b001, 2'd0, 8'hB5, 1'b1, 8'hB5, "load_b5");
    step(1'b0, 3'b010, 2'd3, 8'h00, 1'b1, 8'hA8, "lsl3");
    step(1'b0, 3'b010, 2'd0, 8'hFF, 1'b1, 8'hA8, "lsl0");
    step(1'b0, 3'b011, 2'd0, 8'hFF, 1'b1, 8'hA8, "lsr0");
    step(1'b0, 3'b100, 2'd0, 8'hFF, 1'b1, 8'hA8, "asr0");

    step(1'b0, 3'b001, 2'd0, 8'h5A, 1'b1, 8'h5A, "load_5a");
    step(1'b0, 3'b101, 2'd1, 8'hFF, 1'b1, 8'h5A, "rsv5");
    step(1'b0, 3'b110, 2'd2, 8'hFF, 1'b1, 8'h5A, "rsv6");
    step(1'b0, 3'b111, 2'd3, 8'hFF, 1'b1, 8'h5A, "rsv7");

    // Reset between edges clears q without waiting for a clock.
    step(1'b0, 3'b001, 2'd0, 8'hB5, 1'b1, 8'hB5, "load_b5");
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_q = 0;
    #1;
    direct_check("async_reset_mid", 8'h00);
    step(1'b1, 3'b001, 2'd0, 8'hFF, 1'b1, 8'h00, "held_in_reset");
    step(1'b1, 3'b001, 2'd0, 8'hFF, 1'b1, 8'h00, "held_in_reset");
    step(1'b0, 3'b010, 2'd1, 8'hFF, 1'b1, 8'h00, "first_op_after_reset");
    step(1'b0, 3'b001, 2'd0, 8'hC3, 1'b1, 8'hC3, "load_c3");

    // Randomized operations with occasional asynchronous resets.
    rst_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic prev;
      prev  = rst_v;
      rst_v = prev ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
      step(rst_v, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           8'($urandom), 1'b0, 8'h00, "rand");
      if (rst_v && !prev) begin
        #1;
        direct_check("rand_async_reset", 8'h00);
      end
    end
    @(negedge clk);
    reset = 1'b0;

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
